// File: rtl/lc3_instr_assembler.sv
// Streaming LC-3 instruction encoder: packs one decoded request per handshake
// into a 16-bit word and writes it to program memory at an auto-incrementing pc.
module lc3_instr_assembler #(
  parameter logic [15:0] ORIGIN = 16'h3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        org_valid,
  input  logic [15:0] org_addr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [2:0]  req_dr,
  input  logic [2:0]  req_sr1,
  input  logic [2:0]  req_sr2,
  input  logic        req_imm_mode,
  input  logic [15:0] req_imm,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ready,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] count,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; the sender holds its payload stable until that edge.

  typedef enum logic [1:0] {S_IDLE, S_ENCODE, S_WRITE, S_ERROR} state_t;

  state_t      state, state_nxt;
  logic [15:0] pc;
  logic [3:0]  op_q;
  logic [2:0]  dr_q, sr1_q, sr2_q;
  logic        imm_mode_q;
  logic [15:0] imm_q;
  logic [15:0] off;
  logic [15:0] enc_word;
  logic [1:0]  enc_err;
  logic        fit5, fit6, fit9, fit11;
  logic        accept;

  assign accept = req_valid && req_ready;

  // PC-relative offset is measured from the incremented pc, modulo 2^16.
  assign off   = imm_q - (pc + 16'd1);
  assign fit9  = (&off[15:8])  || !(|off[15:8]);
  assign fit11 = (&off[15:10]) || !(|off[15:10]);
  assign fit5  = (&imm_q[15:4]) || !(|imm_q[15:4]);
  assign fit6  = (&imm_q[15:5]) || !(|imm_q[15:5]);

  always_comb begin
    enc_word = 16'h0000;
    enc_err  = 2'd0;
    case (op_q)
      4'b0001, 4'b0101: begin
        enc_word = {op_q, dr_q, sr1_q, imm_mode_q,
                    imm_mode_q ? imm_q[4:0] : {2'b00, sr2_q}};
        if (imm_mode_q && !fit5) enc_err = 2'd1;
      end
      4'b1001: enc_word = {op_q, dr_q, sr1_q, 6'b111111};
      4'b0000, 4'b0010, 4'b1010, 4'b1110, 4'b0011, 4'b1011: begin
        enc_word = {op_q, dr_q, off[8:0]};
        if (!fit9) enc_err = 2'd1;
      end
      4'b0110, 4'b0111: begin
        enc_word = {op_q, dr_q, sr1_q, imm_q[5:0]};
        if (!fit6) enc_err = 2'd1;
      end
      4'b1100: enc_word = {op_q, 3'b000, sr1_q, 6'b000000};
      4'b0100: begin
        if (imm_mode_q) begin
          enc_word = {op_q, 1'b1, off[10:0]};
          if (!fit11) enc_err = 2'd1;
        end else begin
          enc_word = {op_q, 1'b0, 2'b00, sr1_q, 6'b000000};
        end
      end
      4'b1111: begin
        enc_word = {op_q, 4'b0000, imm_q[7:0]};
        if (|imm_q[15:8]) enc_err = 2'd1;
      end
      default: enc_err = 2'd2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_ENCODE;
      S_ENCODE: state_nxt = (enc_err != 2'd0) ? S_ERROR : S_WRITE;
      S_WRITE:  if (mem_ready) state_nxt = S_IDLE;
      S_ERROR:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    mem_we    = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE:  req_ready = !org_valid && !rst;
      S_WRITE: mem_we = 1'b1;
      S_ERROR: err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= ORIGIN;
      count      <= 16'd0;
      mem_wdata  <= 16'd0;
      err_code   <= 2'd0;
      op_q       <= 4'd0;
      dr_q       <= 3'd0;
      sr1_q      <= 3'd0;
      sr2_q      <= 3'd0;
      imm_mode_q <= 1'b0;
      imm_q      <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (org_valid) begin
            pc    <= org_addr;
            count <= 16'd0;
          end else if (accept) begin
            op_q       <= req_op;
            dr_q       <= req_dr;
            sr1_q      <= req_sr1;
            sr2_q      <= req_sr2;
            imm_mode_q <= req_imm_mode;
            imm_q      <= req_imm;
          end
        end
        S_ENCODE: begin
          // A rejected request leaves the last written word visible.
          if (enc_err != 2'd0) err_code  <= enc_err;
          else                 mem_wdata <= enc_word;
        end
        S_WRITE: begin
          if (mem_ready) begin
            pc    <= pc + 16'd1;
            count <= count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = pc;
  assign dbg_state = state;

endmodule
